// File: rtl/mixer_pkg.sv
// ============================================================================
// mixer_pkg : shared FSM encoding, quad-X sign table and sum-width helper
// Revision  : 1.0
// ============================================================================
`default_nettype none

package mixer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MIX1   = 3'd1,
    S_MIX2   = 3'd2,
    S_MIX3   = 3'd3,
    S_MIX4   = 3'd4,
    S_COMMIT = 3'd5
  } mix_state_t;

  localparam int c_sum_guard_bits = 2;

  // Per motor {roll, pitch, yaw}; a set bit subtracts that term. Index 0 is motor 1.
  localparam logic [3:0][2:0] c_mix_sign_table = {
    3'b010,  // m4 = T + R - P + Y
    3'b111,  // m3 = T - R - P - Y
    3'b100,  // m2 = T - R + P + Y
    3'b001   // m1 = T + R + P - Y
  };

  function automatic int sum_width(input int rate_width);
    return rate_width + c_sum_guard_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mixer_term_sum.sv
// ============================================================================
// mixer_term_sum : signed four-term add with sign select, clamped to [0, MOTOR_MAX]
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mixer_term_sum
  import mixer_pkg::*;
#(
  parameter int RATE_BIT_WIDTH       = 16,
  parameter int MOTOR_RATE_BIT_WIDTH = 16,
  parameter int MOTOR_MAX            = 1000
) (
  input  logic signed [RATE_BIT_WIDTH-1:0]       i_throttle,
  input  logic signed [RATE_BIT_WIDTH-1:0]       i_roll,
  input  logic signed [RATE_BIT_WIDTH-1:0]       i_pitch,
  input  logic signed [RATE_BIT_WIDTH-1:0]       i_yaw,
  input  logic        [2:0]                      i_sign_sel,
  output logic        [MOTOR_RATE_BIT_WIDTH-1:0] o_motor_rate
);

  localparam int c_sum_w = sum_width(RATE_BIT_WIDTH);
  // Compare width covers both the sum and MOTOR_MAX as a positive signed value.
  localparam int c_cmp_w = ((c_sum_w > MOTOR_RATE_BIT_WIDTH + 1) ? c_sum_w
                                                                 : MOTOR_RATE_BIT_WIDTH + 1) + 1;
  localparam logic signed [c_cmp_w-1:0] c_max_cmp = c_cmp_w'(MOTOR_MAX);

  logic signed [c_sum_w-1:0] w_ext_t;
  logic signed [c_sum_w-1:0] w_ext_r;
  logic signed [c_sum_w-1:0] w_ext_p;
  logic signed [c_sum_w-1:0] w_ext_y;
  logic signed [c_sum_w-1:0] w_term_r;
  logic signed [c_sum_w-1:0] w_term_p;
  logic signed [c_sum_w-1:0] w_term_y;
  logic signed [c_sum_w-1:0] w_sum;
  logic signed [c_cmp_w-1:0] w_sum_cmp;

  assign w_ext_t = {{c_sum_guard_bits{i_throttle[RATE_BIT_WIDTH-1]}}, i_throttle};
  assign w_ext_r = {{c_sum_guard_bits{i_roll[RATE_BIT_WIDTH-1]}},     i_roll};
  assign w_ext_p = {{c_sum_guard_bits{i_pitch[RATE_BIT_WIDTH-1]}},    i_pitch};
  assign w_ext_y = {{c_sum_guard_bits{i_yaw[RATE_BIT_WIDTH-1]}},      i_yaw};

  assign w_term_r = i_sign_sel[2] ? -w_ext_r : w_ext_r;
  assign w_term_p = i_sign_sel[1] ? -w_ext_p : w_ext_p;
  assign w_term_y = i_sign_sel[0] ? -w_ext_y : w_ext_y;

  assign w_sum     = w_ext_t + w_term_r + w_term_p + w_term_y;
  assign w_sum_cmp = {{(c_cmp_w - c_sum_w){w_sum[c_sum_w-1]}}, w_sum};

  always_comb begin
    o_motor_rate = '0;
    if (w_sum[c_sum_w-1]) begin
      o_motor_rate = '0;
    end else if (w_sum_cmp > c_max_cmp) begin
      o_motor_rate = MOTOR_RATE_BIT_WIDTH'(MOTOR_MAX);
    end else begin
      o_motor_rate = w_sum_cmp[MOTOR_RATE_BIT_WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/motor_mix_scheduler.sv
// ============================================================================
// motor_mix_scheduler : time-multiplexed quad-X mixer with atomic commit and arming
// Revision            : 1.0
// ============================================================================
`default_nettype none

module motor_mix_scheduler
  import mixer_pkg::*;
#(
  parameter int RATE_BIT_WIDTH       = 16,
  parameter int MOTOR_RATE_BIT_WIDTH = 16,
  parameter int MOTOR_MAX            = 1000
) (
  input  logic                                   sys_clk,
  input  logic                                   reset,
  input  logic signed [RATE_BIT_WIDTH-1:0]       throttle_rate,
  input  logic signed [RATE_BIT_WIDTH-1:0]       yaw_rate,
  input  logic signed [RATE_BIT_WIDTH-1:0]       roll_rate,
  input  logic signed [RATE_BIT_WIDTH-1:0]       pitch_rate,
  input  logic                                   start,
  input  logic                                   armed,
  output logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate,
  output logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate,
  output logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate,
  output logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   overrun
);

  mix_state_t                                r_state;
  logic signed [RATE_BIT_WIDTH-1:0]          r_hold_throttle;
  logic signed [RATE_BIT_WIDTH-1:0]          r_hold_yaw;
  logic signed [RATE_BIT_WIDTH-1:0]          r_hold_roll;
  logic signed [RATE_BIT_WIDTH-1:0]          r_hold_pitch;
  logic [3:0][MOTOR_RATE_BIT_WIDTH-1:0]      r_stage;

  logic [1:0]                                w_mix_idx;
  logic [2:0]                                w_sign_sel;
  logic [MOTOR_RATE_BIT_WIDTH-1:0]           w_mix_result;

  always_comb begin
    w_mix_idx = 2'd0;
    case (r_state)
      S_MIX1:  w_mix_idx = 2'd0;
      S_MIX2:  w_mix_idx = 2'd1;
      S_MIX3:  w_mix_idx = 2'd2;
      S_MIX4:  w_mix_idx = 2'd3;
      default: w_mix_idx = 2'd0;
    endcase
  end

  assign w_sign_sel = c_mix_sign_table[w_mix_idx];

  // Single adder/saturator shared by all four MIX states.
  mixer_term_sum #(
    .RATE_BIT_WIDTH       (RATE_BIT_WIDTH),
    .MOTOR_RATE_BIT_WIDTH (MOTOR_RATE_BIT_WIDTH),
    .MOTOR_MAX            (MOTOR_MAX)
  ) u_term_sum (
    .i_throttle   (r_hold_throttle),
    .i_roll       (r_hold_roll),
    .i_pitch      (r_hold_pitch),
    .i_yaw        (r_hold_yaw),
    .i_sign_sel   (w_sign_sel),
    .o_motor_rate (w_mix_result)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_hold_throttle <= '0;
      r_hold_yaw      <= '0;
      r_hold_roll     <= '0;
      r_hold_pitch    <= '0;
      r_stage         <= '0;
      motor_1_rate    <= '0;
      motor_2_rate    <= '0;
      motor_3_rate    <= '0;
      motor_4_rate    <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= start && (r_state != S_IDLE);

      if ((r_state != S_IDLE) && !armed) begin
        // Disarm mid-mix: abandon the update and force motors off.
        r_state      <= S_IDLE;
        busy         <= 1'b0;
        motor_1_rate <= '0;
        motor_2_rate <= '0;
        motor_3_rate <= '0;
        motor_4_rate <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!armed) begin
              motor_1_rate <= '0;
              motor_2_rate <= '0;
              motor_3_rate <= '0;
              motor_4_rate <= '0;
            end else if (start) begin
              r_hold_throttle <= throttle_rate;
              r_hold_yaw      <= yaw_rate;
              r_hold_roll     <= roll_rate;
              r_hold_pitch    <= pitch_rate;
              busy            <= 1'b1;
              r_state         <= S_MIX1;
            end
          end
          S_MIX1: begin
            r_stage[w_mix_idx] <= w_mix_result;
            r_state            <= S_MIX2;
          end
          S_MIX2: begin
            r_stage[w_mix_idx] <= w_mix_result;
            r_state            <= S_MIX3;
          end
          S_MIX3: begin
            r_stage[w_mix_idx] <= w_mix_result;
            r_state            <= S_MIX4;
          end
          S_MIX4: begin
            r_stage[w_mix_idx] <= w_mix_result;
            r_state            <= S_COMMIT;
          end
          S_COMMIT: begin
            motor_1_rate <= r_stage[0];
            motor_2_rate <= r_stage[1];
            motor_3_rate <= r_stage[2];
            motor_4_rate <= r_stage[3];
            done         <= 1'b1;
            busy         <= 1'b0;
            r_state      <= S_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_motor_mix_scheduler.sv
// ============================================================================
// tb_motor_mix_scheduler : vector table, directed corner cases and random run vs. model
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_motor_mix_scheduler;

  localparam int RW   = 16;
  localparam int MW   = 16;
  localparam int MMAX = 1000;

  logic                 sys_clk = 1'b0;
  logic                 reset   = 1'b1;
  logic signed [RW-1:0] throttle_rate = '0;
  logic signed [RW-1:0] yaw_rate      = '0;
  logic signed [RW-1:0] roll_rate     = '0;
  logic signed [RW-1:0] pitch_rate    = '0;
  logic                 start = 1'b0;
  logic                 armed = 1'b0;
  logic [MW-1:0]        motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate;
  logic                 busy, done, overrun;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  motor_mix_scheduler #(
    .RATE_BIT_WIDTH       (RW),
    .MOTOR_RATE_BIT_WIDTH (MW),
    .MOTOR_MAX            (MMAX)
  ) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .throttle_rate (throttle_rate),
    .yaw_rate      (yaw_rate),
    .roll_rate     (roll_rate),
    .pitch_rate    (pitch_rate),
    .start         (start),
    .armed         (armed),
    .motor_1_rate  (motor_1_rate),
    .motor_2_rate  (motor_2_rate),
    .motor_3_rate  (motor_3_rate),
    .motor_4_rate  (motor_4_rate),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Quad-X mix from the sign table, clamped to [0, MMAX].
  function automatic int mix_ref(input int t, input int r, input int p, input int y, input int k);
    int s;
    case (k)
      0:       s = t + r + p - y;
      1:       s = t - r + p + y;
      2:       s = t - r - p - y;
      default: s = t + r - p + y;
    endcase
    if (s < 0) s = 0;
    if (s > MMAX) s = MMAX;
    return s;
  endfunction

  // Transaction-level model: cycles elapsed since an accepted start, 0 = idle.
  int m_phase = 0;
  int m_t = 0, m_r = 0, m_p = 0, m_y = 0;
  int m_out [4] = '{0, 0, 0, 0};
  bit m_busy = 0, m_done = 0, m_ovr = 0;

  function automatic logic [79:0] dut_vec();
    return {13'd0, motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate, busy, done, overrun};
  endfunction

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_t = 0; m_r = 0; m_p = 0; m_y = 0;
      m_out = '{0, 0, 0, 0};
      m_busy = 0; m_done = 0; m_ovr = 0;
    end else begin
      m_done = 0;
      m_ovr  = start && (m_phase != 0);
      if (m_phase != 0 && !armed) begin
        m_phase = 0; m_busy = 0;
        m_out = '{0, 0, 0, 0};
      end else if (m_phase == 0) begin
        if (!armed) begin
          m_out = '{0, 0, 0, 0};
        end else if (start) begin
          m_t = int'(throttle_rate); m_r = int'(roll_rate);
          m_p = int'(pitch_rate);    m_y = int'(yaw_rate);
          m_phase = 1; m_busy = 1;
        end
      end else if (m_phase < 5) begin
        m_phase++;
      end else begin
        for (int k = 0; k < 4; k++) m_out[k] = mix_ref(m_t, m_r, m_p, m_y, k);
        m_done = 1; m_busy = 0; m_phase = 0;
      end
    end
    #2;
    if (mon_en)
      check("model", dut_vec(),
            {13'd0, 16'(m_out[0]), 16'(m_out[1]), 16'(m_out[2]), 16'(m_out[3]), m_busy, m_done, m_ovr});
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_rates(input int t, input int r, input int p, input int y);
    throttle_rate = 16'(t); roll_rate = 16'(r); pitch_rate = 16'(p); yaw_rate = 16'(y);
  endtask

  function automatic logic [79:0] motors();
    return {16'd0, motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate};
  endfunction

  function automatic logic [79:0] motors_exp(input int a, input int b, input int c, input int d);
    return {16'd0, 16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  typedef struct {
    int t, r, p, y;
    int m1, m2, m3, m4;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v);
    set_rates(v.t, v.r, v.p, v.y);
    armed = 1'b1; start = 1'b1;
    step();                                   // E0
    start = 1'b0;
    check("busy_after_e0", {78'd0, busy, done}, {78'd0, 1'b1, 1'b0});
    for (int i = 1; i <= 4; i++) begin
      step();                                 // E1..E4
      check("busy_mix", {78'd0, busy, done}, {78'd0, 1'b1, 1'b0});
    end
    step();                                   // E5
    check("commit_flags", {78'd0, busy, done}, {78'd0, 1'b0, 1'b1});
    check("commit_motors", motors(), motors_exp(v.m1, v.m2, v.m3, v.m4));
    step();
    check("done_one_cycle", {79'd0, done}, 80'd0);
  endtask

  int ovr_cnt;
  int done_cnt;

  initial begin
    vecs[0] = '{500,    0,      0,      0,     500,  500,  500,  500};
    vecs[1] = '{500,    100,    0,      0,     600,  400,  400,  600};
    vecs[2] = '{900,    200,    100,    0,     1000, 800,  600,  1000};
    vecs[3] = '{50,     -100,   0,      0,     0,    150,  150,  0};
    vecs[4] = '{400,    0,      0,      50,    350,  450,  350,  450};
    vecs[5] = '{400,    0,      -80,    0,     320,  320,  480,  480};
    vecs[6] = '{1000,   0,      0,      0,     1000, 1000, 1000, 1000};
    vecs[7] = '{1001,   0,      0,      0,     1000, 1000, 1000, 1000};
    vecs[8] = '{-1,     0,      0,      0,     0,    0,    0,    0};
    vecs[9] = '{32767,  -32768, -32768, 32767, 0,    1000, 1000, 1000};

    step();
    check("reset_state", dut_vec(), 80'd0);
    #2 reset = 1'b0;
    mon_en = 1'b1;
    step();
    check("idle_after_reset", dut_vec(), 80'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Overrun: second start at E2 is dropped, first mix commits unchanged.
    set_rates(300, 0, 0, 0); armed = 1'b1; start = 1'b1;
    step(); start = 1'b0;                     // E0
    step();                                   // E1
    set_rates(700, 0, 0, 0); start = 1'b1;
    step(); start = 1'b0;                     // E2
    check("overrun_pulse", {79'd0, overrun}, {79'd0, 1'b1});
    ovr_cnt = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (overrun) ovr_cnt++;
    end
    check("overrun_count", 80'(ovr_cnt), 80'd1);
    check("overrun_done", {79'd0, done}, {79'd0, 1'b1});
    check("overrun_motors", motors(), motors_exp(300, 300, 300, 300));
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("overrun_no_second", 80'(done_cnt), 80'd0);

    // Disarm during MIX3.
    set_rates(500, 0, 0, 0); start = 1'b1;
    step(); start = 1'b0;                     // E0
    step(); step();                           // E1, E2 -> in MIX3
    armed = 1'b0;
    step();
    check("disarm_abort", dut_vec(), 80'd0);
    start = 1'b1;
    step(); start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (done || busy) done_cnt++;
      step();
    end
    check("disarm_start_ignored", {16'd0, 16'(done_cnt), 48'd0}, 80'd0);
    check("disarm_motors", motors(), 80'd0);

    // Async reset during MIX2 with outputs at 500.
    armed = 1'b1;
    run_vec(vecs[0]);
    set_rates(200, 0, 0, 0); start = 1'b1;
    step(); start = 1'b0;                     // E0
    step();                                   // E1 -> in MIX2
    #3 reset = 1'b1;
    #1;
    check("async_reset", dut_vec(), 80'd0);
    #1 reset = 1'b0;
    step();
    check("after_reset_idle", dut_vec(), 80'd0);
    run_vec(vecs[1]);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      armed = ($urandom_range(0, 15) != 0);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        throttle_rate = 16'($urandom); roll_rate = 16'($urandom);
        pitch_rate    = 16'($urandom); yaw_rate  = 16'($urandom);
      end else begin
        set_rates(int'($urandom_range(0, 1400)) - 200, int'($urandom_range(0, 600)) - 300,
                  int'($urandom_range(0, 600)) - 300,  int'($urandom_range(0, 600)) - 300);
      end
      step();
    end
    start = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
